uart_rx_word_assembler: RTL and testbench
=========================================

// Module: uart_rx_word_assembler
// PURPOSE
// - Packs the byte stream from the UART receiver (RxData/RxDone) into 32-bit words.
// - RX-side mirror of the 32-to-8 TX serializer. Sits between UART_rs232_rx and the
//   word consumers: command decoder, register/memory write path.
// - Adds an inter-byte timeout so a lost byte cannot misalign every later word.
// - Adds a valid/ready handoff and an overrun flag.
// PARAMETERS
// - NBYTES       4        bytes per word; word width = 8*NBYTES (32 at default)
// - MSB_FIRST    1        1: first byte received -> [31:24]; 0: first byte -> [7:0]
// - TIMEOUT_CYC  200000   Clk cycles without rx_done before a partial word is dropped (~4 byte times @9600, 50 MHz)
// - TO_W         18       timeout counter width; TIMEOUT_CYC must be < 2**TO_W
// PORTS
// - Clk         in   1   system clock, rising edge
// - Rst_n       in   1   asynchronous active-low reset
// - rx_done     in   1   one-cycle pulse from UART RX: rx_data valid
// - rx_data     in   8   received byte
// - word_out    out  32  assembled word; stable while word_valid=1
// - word_valid  out  1   word available
// - word_ready  in   1   consumer accepts word_out on a rising edge where valid&ready
// - byte_cnt    out  2   bytes held in the current partial word (0..NBYTES-1)
// - overrun     out  1   one-cycle pulse: a byte arrived in HOLD and was dropped
// - timeout     out  1   one-cycle pulse: a partial word was discarded on idle timeout
// BEHAVIOUR
// - Reset (async, Rst_n=0):
//   - FSM=IDLE; word_out=0; word_valid=0; byte_cnt=0; overrun=0; timeout=0; timer=0.
//   - Reset mid-word or during HOLD discards everything. No flag is raised.
// - IDLE:
//   - rx_done -> capture byte 0 -> COLLECT, byte_cnt=1, timer cleared.
// - COLLECT:
//   - Each rx_done stores the byte in slot byte_cnt, increments byte_cnt and clears the timer.
//   - On the NBYTES-th byte: -> HOLD, byte_cnt=0.
//   - word_valid rises the cycle after that rx_done (latency 1 clk from the last RxDone).
//   - No rx_done: timer increments.
//   - Timer reaches TIMEOUT_CYC-1 with no rx_done: timeout=1 for 1 clk, partial cleared,
//     byte_cnt=0 -> IDLE.
//   - rx_done on the timeout cycle wins: the byte is stored, no timeout.
// - HOLD:
//   - word_valid=1 and word_out frozen until a word_ready sample.
//   - Timer frozen at 0 (no timeout in HOLD).
//   - valid&ready with no rx_done: word_valid=0 next cycle -> IDLE.
//   - valid&ready and rx_done in the same cycle: handoff completes, byte becomes byte 0 of
//     the next word -> COLLECT, byte_cnt=1. No overrun.
//   - rx_done without ready: byte dropped, overrun=1 for 1 clk, stays in HOLD.
// - Byte placement:
//   - MSB_FIRST=1: slot k -> word[8*(NBYTES-1-k)+:8].
//   - MSB_FIRST=0: slot k -> word[8*k+:8].
//   - Unwritten bits are 0; the shift/assembly register is cleared on entry to IDLE.
// - word_ready outside HOLD is ignored.
// - rx_done pulses only; a level held high counts as one byte per clock.
// STRUCTURE
// - Shared package (uart_pkg):
//   - state encoding IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2;
//   - UART_NBYTES=4, UART_TIMEOUT_CYC=200000, UART_TO_W=18.
// - One sub-module, rx_idle_timer:
//   - inputs: clr, en;
//   - output: expire (registered, 1-clk pulse at TIMEOUT_CYC-1);
//   - counter saturates/clears on clr.
// - Top: FSM, assembly register, byte counter, output flags, all in one always block
//   plus the timer instance.
// TESTING
// - Reset/idle:
//   - stimulus: Rst_n low 5 clk, then idle 100 clk;
//   - required: all outputs 0, byte_cnt=0, no flag pulses.
// - Basic MSB-first word:
//   - stimulus: bytes 0xDE,0xAD,0xBE,0xEF, word_ready held 1;
//   - required: word_out=32'hDEADBEEF with word_valid for exactly 1 clk, one clk after the 4th rx_done.
// - LSB-first build (MSB_FIRST=0):
//   - stimulus: bytes 0x01,0x02,0x03,0x04;
//   - required: word_out=32'h04030201.
// - Backpressure/overrun:
//   - stimulus: word_ready=0 after word 0x11223344 completes, extra byte 0x55;
//   - required: overrun pulse 1 clk; word_out stays 0x11223344;
//   - required: after ready, next word excludes 0x55.
// - Handoff collision:
//   - stimulus: word_ready and rx_done(0xAA) in the same cycle while in HOLD;
//   - required: word accepted, byte_cnt=1;
//   - required: next word after 0xBB,0xCC,0xDD = 32'hAABBCCDD.
// - Timeout/reset:
//   - stimulus: 2 bytes then silence TIMEOUT_CYC clk (test TIMEOUT_CYC=50);
//   - required: timeout pulse, byte_cnt=0;
//   - required: next 4 bytes 0x01..0x04 -> 32'h01020304;
//   - stimulus: repeat with Rst_n pulsed after 3 bytes;
//   - required: no word_valid, no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive word path: FSM encoding, default
// sizing and the byte-slot placement helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } rx_state_e;

    localparam int UART_NBYTES      = 4;
    localparam int UART_TIMEOUT_CYC = 200000;
    localparam int UART_TO_W        = 18;

    // Bit offset of byte slot 'slot' inside an nbytes-wide word.
    function automatic int slot_lsb(input int slot, input int nbytes, input bit msb_first);
        return msb_first ? 8 * (nbytes - 1 - slot) : 8 * slot;
    endfunction

endpackage

// File: rtl/uart_rx_word_assembler_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and emits
// a registered one-cycle expire pulse when the count reaches TIMEOUT_CYC-1.
module rx_idle_timer
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = UART_TIMEOUT_CYC,
    parameter int TO_W        = UART_TO_W
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] CNT_PRE  = TO_W'(TIMEOUT_CYC - 2);

    logic [TO_W-1:0] count_q, count_d;
    logic            expire_q, expire_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        count_d  = count_q;
        expire_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q != CNT_LAST) count_d = count_q + TO_W'(1);
            // Registered so the pulse lines up with the count reaching CNT_LAST.
            expire_d = (count_q == CNT_PRE);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values.
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs UART RX bytes into NBYTES-wide words with a valid/ready handoff,
// overrun reporting and an inter-byte timeout that drops stale partial words.
module uart_rx_word_assembler
    import uart_pkg::*;
#(
    parameter int   NBYTES      = UART_NBYTES,
    parameter bit   MSB_FIRST   = 1'b1,
    parameter int   TIMEOUT_CYC = UART_TIMEOUT_CYC,
    parameter int   TO_W        = UART_TO_W,
    localparam int  CNT_W       = $clog2(NBYTES),
    localparam int  WORD_W      = 8 * NBYTES
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              overrun,
    output logic              timeout
);

    rx_state_e         state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              timer_expire;

    // Timer only runs while a partial word is pending; any byte restarts it.
    rx_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timer (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .clr    (rx_done || (state_q != COLLECT)),
        .en     (state_q == COLLECT),
        .expire (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                word_d = '0;
                if (rx_done) begin
                    word_d[slot_lsb(0, NBYTES, MSB_FIRST) +: 8] = rx_data;
                    byte_cnt_d = CNT_W'(1);
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                // A byte arriving on the expire cycle takes priority over the timeout.
                if (rx_done) begin
                    word_d[slot_lsb(int'(byte_cnt_q), NBYTES, MSB_FIRST) +: 8] = rx_data;
                    if (byte_cnt_q == CNT_W'(NBYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end else if (timer_expire) begin
                    timeout_d  = 1'b1;
                    word_d     = '0;
                    byte_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    word_d = '0;
                    if (rx_done) begin
                        word_d[slot_lsb(0, NBYTES, MSB_FIRST) +: 8] = rx_data;
                        byte_cnt_d = CNT_W'(1);
                        state_d    = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (rx_done) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                word_d     = '0;
                byte_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            byte_cnt_q <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == HOLD);
    assign byte_cnt   = byte_cnt_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench: an MSB-first and an LSB-first assembler (short timeout) share
// one byte stream; expected words are hand-computed constants.
module tb_uart_rx_word_assembler;

    localparam int TO_CYC = 50;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        word_ready;

    logic [31:0] word_out,   word_out_l;
    logic        word_valid, word_valid_l;
    logic [1:0]  byte_cnt,   byte_cnt_l;
    logic        overrun,    overrun_l;
    logic        timeout,    timeout_l;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_pulses = 0, to_pulses = 0, valid_cycles = 0;
    int ovr_base, to_base, valid_base;

    uart_rx_word_assembler #(.NBYTES(4), .MSB_FIRST(1'b1), .TIMEOUT_CYC(TO_CYC), .TO_W(18)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .rx_done(rx_done), .rx_data(rx_data),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .byte_cnt(byte_cnt), .overrun(overrun), .timeout(timeout)
    );

    uart_rx_word_assembler #(.NBYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYC(TO_CYC), .TO_W(18)) dut_lsb (
        .Clk(Clk), .Rst_n(Rst_n), .rx_done(rx_done), .rx_data(rx_data),
        .word_out(word_out_l), .word_valid(word_valid_l), .word_ready(word_ready),
        .byte_cnt(byte_cnt_l), .overrun(overrun_l), .timeout(timeout_l)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (overrun)    ovr_pulses++;
        if (timeout)    to_pulses++;
        if (word_valid) valid_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic snap();
        ovr_base   = ovr_pulses;
        to_base    = to_pulses;
        valid_base = valid_cycles;
    endtask

    initial begin
        Rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; word_ready = 1'b0;

        // Reset and idle
        tick(5);
        check("rst_word",  word_out, 32'h0);
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_cnt",   32'(byte_cnt), 32'h0);
        check("rst_flags", {30'h0, overrun, timeout}, 32'h0);
        Rst_n = 1'b1;
        snap();
        tick(100);
        check("idle_valid", 32'(word_valid), 32'h0);
        check("idle_cnt",   32'(byte_cnt), 32'h0);
        check("idle_pulses", 32'(ovr_pulses - ovr_base + to_pulses - to_base + valid_cycles - valid_base), 32'h0);

        // Basic MSB-first word with ready held high
        word_ready = 1'b1;
        snap();
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        check("msb_cnt3", 32'(byte_cnt), 32'd3);
        check("msb_valid_early", 32'(word_valid), 32'h0);
        send_byte(8'hEF);
        check("msb_valid", 32'(word_valid), 32'h1);
        check("msb_word",  word_out, 32'hDEADBEEF);
        check("msb_lsbinst_word", word_out_l, 32'hEFBEADDE);
        check("msb_cnt0",  32'(byte_cnt), 32'h0);
        tick();
        check("msb_valid_drop", 32'(word_valid), 32'h0);
        tick(3);
        check("msb_valid_width", 32'(valid_cycles - valid_base), 32'd1);

        // LSB-first build
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("lsb_valid", 32'(word_valid_l), 32'h1);
        check("lsb_word",  word_out_l, 32'h04030201);
        check("lsb_msbinst_word", word_out, 32'h01020304);
        tick(2);

        // Backpressure and overrun
        word_ready = 1'b0;
        snap();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("bp_word", word_out, 32'h11223344);
        send_byte(8'h55);
        check("bp_overrun", 32'(overrun), 32'h1);
        tick();
        check("bp_overrun_drop", 32'(overrun), 32'h0);
        check("bp_word_hold", word_out, 32'h11223344);
        check("bp_valid_hold", 32'(word_valid), 32'h1);
        check("bp_ovr_count", 32'(ovr_pulses - ovr_base), 32'd1);
        word_ready = 1'b1;
        tick();
        check("bp_accept", 32'(word_valid), 32'h0);
        send_byte(8'h66); send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
        check("bp_next_word", word_out, 32'h66778899);
        tick(2);

        // Handoff collision: ready and rx_done together in HOLD
        word_ready = 1'b0;
        snap();
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        check("col_hold", word_out, 32'hA1A2A3A4);
        word_ready = 1'b1;
        send_byte(8'hAA);
        check("col_accept", 32'(word_valid), 32'h0);
        check("col_cnt1",   32'(byte_cnt), 32'd1);
        check("col_no_ovr", 32'(ovr_pulses - ovr_base), 32'h0);
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("col_word", word_out, 32'hAABBCCDD);
        tick(2);

        // Idle timeout on a 2-byte partial word
        snap();
        send_byte(8'hAB); send_byte(8'hCD);
        check("to_cnt2", 32'(byte_cnt), 32'd2);
        tick(TO_CYC - 1);
        check("to_not_yet", 32'(timeout), 32'h0);
        check("to_cnt_kept", 32'(byte_cnt), 32'd2);
        tick();
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_cnt_clr", 32'(byte_cnt), 32'h0);
        check("to_word_clr", word_out, 32'h0);
        tick();
        check("to_pulse_drop", 32'(timeout), 32'h0);

        // A byte on the expire cycle wins over the timeout
        send_byte(8'h01); send_byte(8'h02);
        tick(TO_CYC - 1);
        send_byte(8'h03);
        check("tow_no_timeout", 32'(timeout), 32'h0);
        check("tow_cnt3", 32'(byte_cnt), 32'd3);
        tick(TO_CYC);
        check("tow_late_pulse", 32'(timeout), 32'h1);
        tick();
        check("to_count", 32'(to_pulses - to_base), 32'd2);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("to_next_word", word_out, 32'h01020304);
        tick(2);

        // Reset in the middle of a word
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        Rst_n = 1'b0;
        tick();
        check("mr_cnt", 32'(byte_cnt), 32'h0);
        Rst_n = 1'b1;
        snap();
        tick(TO_CYC + 10);
        check("mr_quiet", 32'(ovr_pulses - ovr_base + to_pulses - to_base + valid_cycles - valid_base), 32'h0);
        check("mr_word", word_out, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
